// File: rtl/rvfi_dmem_window_check_pkg.sv
// Shared types and helpers for the RVFI data-memory window checker.
// word_index maps an access address onto the shadowed window.
package rvfi_check_pkg;

    typedef struct packed {
        logic       hit;
        logic [5:0] idx;
    } widx_t;

    function automatic int unsigned xlen_bytes(input int unsigned xlen);
        return xlen / 8;
    endfunction

    function automatic int unsigned widx_width(input int unsigned nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

    // Word distance is taken modulo 2^(xlen - log2(bytes)), so wrap-around lands far away and misses.
    function automatic widx_t word_index(input logic [63:0] addr, input logic [63:0] base,
                                         input int unsigned xlen, input int unsigned nwords);
        int unsigned sh;
        logic [63:0] diff;
        widx_t       r;
        sh     = (xlen == 64) ? 3 : 2;
        diff   = (addr >> sh) - (base >> sh);
        diff   = diff & ((64'd1 << (xlen - sh)) - 64'd1);
        r.hit  = (diff < 64'(nwords));
        r.idx  = diff[5:0];
        return r;
    endfunction

endpackage

// File: rtl/rvfi_dmem_window_check_lane.sv
// One retirement channel acting on one shadowed word: compare readable bytes,
// then apply the channel's write so later channels see it.
module rvfi_dmem_lane
    import rvfi_check_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                 i_en,
    input  logic [XLEN-1:0]      i_shadow,
    input  logic [XLEN/8-1:0]    i_written,
    input  logic [XLEN/8-1:0]    i_rmask,
    input  logic [XLEN/8-1:0]    i_wmask,
    input  logic [XLEN-1:0]      i_rdata,
    input  logic [XLEN-1:0]      i_wdata,
    output logic [XLEN-1:0]      o_shadow,
    output logic [XLEN/8-1:0]    o_written,
    output logic [XLEN/8-1:0]    o_mism,
    output logic [3:0]           o_cnt
);

    always_comb begin
        o_shadow  = i_shadow;
        o_written = i_written;
        o_mism    = '0;
        o_cnt     = '0;
        for (int unsigned i = 0; i < XLEN / 8; i++) begin
            // Compare uses the incoming shadow, so a same-channel write never masks a bad read.
            if (i_en && i_rmask[i] && i_written[i]) begin
                o_cnt = o_cnt + 4'd1;
                if (i_rdata[8*i +: 8] != i_shadow[8*i +: 8])
                    o_mism[i] = 1'b1;
            end
            if (i_en && i_wmask[i]) begin
                o_shadow[8*i +: 8] = i_wdata[8*i +: 8];
                o_written[i]       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvfi_dmem_window_check.sv
// RVFI data-memory consistency checker over a window of NWORDS shadowed words.
// Reports the first load/shadow mismatch since reset on registered outputs.
module rvfi_dmem_window_check
    import rvfi_check_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NRET      = 1,
    parameter int unsigned NWORDS    = 4,
    parameter bit          ASSERT_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [XLEN-1:0]          dmem_base,
    input  logic [NRET-1:0]          rvfi_valid,
    input  logic [NRET*64-1:0]       rvfi_order,
    input  logic [NRET-1:0]          rvfi_trap,
    input  logic [NRET*XLEN-1:0]     rvfi_mem_addr,
    input  logic [NRET*XLEN/8-1:0]   rvfi_mem_rmask,
    input  logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask,
    input  logic [NRET*XLEN-1:0]     rvfi_mem_rdata,
    input  logic [NRET*XLEN-1:0]     rvfi_mem_wdata,
    output logic                     err,
    output logic                     err_valid,
    output logic [63:0]              err_order,
    output logic [5:0]               err_word,
    output logic [2:0]               err_byte,
    output logic [31:0]              check_count
);

    localparam int unsigned NB = xlen_bytes(XLEN);

    logic [XLEN-1:0] r_shadow  [NWORDS];
    logic [NB-1:0]   r_written [NWORDS];
    logic            r_err;
    logic            r_err_valid;
    logic [63:0]     r_err_order;
    logic [5:0]      r_err_word;
    logic [2:0]      r_err_byte;
    logic [31:0]     r_cnt;

    widx_t           w_wi   [NRET];
    logic            w_en   [NWORDS][NRET];
    logic [XLEN-1:0] w_sh   [NWORDS][NRET+1];
    logic [NB-1:0]   w_wr   [NWORDS][NRET+1];
    logic [NB-1:0]   w_mism [NWORDS][NRET];
    logic [3:0]      w_cnt  [NWORDS][NRET];

    logic            w_any;
    logic [63:0]     w_f_order;
    logic [5:0]      w_f_word;
    logic [2:0]      w_f_byte;
    logic [31:0]     w_sum;
    logic [32:0]     w_cnt_next;
    logic [NB-1:0]   w_ch_mism;

    always_comb begin
        for (int unsigned k = 0; k < NRET; k++) begin
            w_wi[k] = word_index(64'(rvfi_mem_addr[k*XLEN +: XLEN]), 64'(dmem_base), XLEN, NWORDS);
        end
        for (int unsigned w = 0; w < NWORDS; w++) begin
            for (int unsigned k = 0; k < NRET; k++) begin
                w_en[w][k] = rvfi_valid[k] && !rvfi_trap[k] && w_wi[k].hit && (w_wi[k].idx == 6'(w));
            end
        end
    end

    // Each word is a chain of NRET lane stages; stage k sees the writes of stages 0..k-1.
    for (genvar w = 0; w < NWORDS; w++) begin : g_word
        assign w_sh[w][0] = r_shadow[w];
        assign w_wr[w][0] = r_written[w];
        for (genvar k = 0; k < NRET; k++) begin : g_ch
            rvfi_dmem_lane #(.XLEN(XLEN)) u_lane (
                .i_en      (w_en[w][k]),
                .i_shadow  (w_sh[w][k]),
                .i_written (w_wr[w][k]),
                .i_rmask   (rvfi_mem_rmask[k*NB +: NB]),
                .i_wmask   (rvfi_mem_wmask[k*NB +: NB]),
                .i_rdata   (rvfi_mem_rdata[k*XLEN +: XLEN]),
                .i_wdata   (rvfi_mem_wdata[k*XLEN +: XLEN]),
                .o_shadow  (w_sh[w][k+1]),
                .o_written (w_wr[w][k+1]),
                .o_mism    (w_mism[w][k]),
                .o_cnt     (w_cnt[w][k])
            );
        end
    end

    always_comb begin
        w_any     = 1'b0;
        w_f_order = '0;
        w_f_word  = '0;
        w_f_byte  = '0;
        w_sum     = '0;
        w_ch_mism = '0;
        for (int unsigned k = 0; k < NRET; k++) begin
            w_ch_mism = '0;
            for (int unsigned w = 0; w < NWORDS; w++) begin
                w_sum     = w_sum + 32'(w_cnt[w][k]);
                w_ch_mism = w_ch_mism | w_mism[w][k];
            end
            for (int unsigned i = 0; i < NB; i++) begin
                if (!w_any && w_ch_mism[i]) begin
                    w_any     = 1'b1;
                    w_f_order = rvfi_order[k*64 +: 64];
                    w_f_word  = w_wi[k].idx;
                    w_f_byte  = 3'(i);
                end
            end
        end
        w_cnt_next = {1'b0, r_cnt} + {1'b0, w_sum};
    end

    // Shadow data carries no reset; the written bits alone decide what is compared.
    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < NWORDS; w++) begin
            r_shadow[w] <= w_sh[w][NRET];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned w = 0; w < NWORDS; w++) begin
                r_written[w] <= '0;
            end
            r_err       <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_order <= '0;
            r_err_word  <= '0;
            r_err_byte  <= '0;
            r_cnt       <= '0;
        end else begin
            for (int unsigned w = 0; w < NWORDS; w++) begin
                r_written[w] <= w_wr[w][NRET];
            end
            r_err_valid <= w_any && !r_err;
            if (w_any && !r_err) begin
                r_err       <= 1'b1;
                r_err_order <= w_f_order;
                r_err_word  <= w_f_word;
                r_err_byte  <= w_f_byte;
            end
            r_cnt <= w_cnt_next[32] ? '1 : w_cnt_next[31:0];
        end
    end

    if (ASSERT_EN) begin : g_assert
        a_no_mismatch: assert property (@(posedge clk) disable iff (!resetn) !w_any);
    end

    assign err         = r_err;
    assign err_valid   = r_err_valid;
    assign err_order   = r_err_order;
    assign err_word    = r_err_word;
    assign err_byte    = r_err_byte;
    assign check_count = r_cnt;

endmodule
